// File: rtl/pong_gfx_pkg.sv
// rtl/pong_gfx_pkg.sv - shared graphics types and colour constants for the pong display path
package pong_gfx_pkg;

  localparam int GFX_COORD_W  = 16;
  localparam int GFX_COLOUR_W = 8;

  typedef logic [GFX_COORD_W-1:0]  coord_t;
  typedef logic [GFX_COLOUR_W-1:0] colour_t;

  localparam colour_t COLOUR_WHITE = 8'hFF;
  localparam colour_t COLOUR_BLACK = 8'h00;

  typedef struct packed {
    coord_t x;
    coord_t y;
    coord_t w;
    coord_t h;
  } obj_rect_t;

endpackage

// File: rtl/pong_sprite_compositor_if.sv
// rtl/pong_sprite_compositor_if.sv - raster coordinate in / pixel colour out stream bundle
interface pong_sprite_compositor_if #(
  parameter int COORD_W  = 16,
  parameter int N_OBJ    = 3,
  parameter int COLOUR_W = 8
);
  localparam int OBJ_W = $clog2(N_OBJ + 1);

  logic                px_valid;
  logic [COORD_W-1:0]  px_x;
  logic [COORD_W-1:0]  px_y;
  logic                pix_valid;
  logic [COLOUR_W-1:0] pix_colour;
  logic [OBJ_W-1:0]    pix_obj;

  // raster generator side
  modport master (
    output px_valid, px_x, px_y,
    input  pix_valid, pix_colour, pix_obj
  );

  // compositor side
  modport slave (
    input  px_valid, px_x, px_y,
    output pix_valid, pix_colour, pix_obj
  );
endinterface

// File: rtl/rect_hit_test.sv
// rtl/rect_hit_test.sv - combinational point-in-rectangle test with clipping at the coordinate limit
module rect_hit_test #(
  parameter int COORD_W = 16
) (
  input  logic [COORD_W-1:0] rect_x_i,
  input  logic [COORD_W-1:0] rect_y_i,
  input  logic [COORD_W-1:0] rect_w_i,
  input  logic [COORD_W-1:0] rect_h_i,
  input  logic [COORD_W-1:0] px_x_i,
  input  logic [COORD_W-1:0] px_y_i,
  output logic               hit_o
);
  // One extra bit keeps the offset from wrapping; a rectangle running past
  // the top coordinate simply has no pixels beyond it.
  logic [COORD_W:0] dx;
  logic [COORD_W:0] dy;
  logic             in_x;
  logic             in_y;

  assign dx   = {1'b0, px_x_i} - {1'b0, rect_x_i};
  assign dy   = {1'b0, px_y_i} - {1'b0, rect_y_i};
  assign in_x = (px_x_i >= rect_x_i) && (dx < {1'b0, rect_w_i});
  assign in_y = (px_y_i >= rect_y_i) && (dy < {1'b0, rect_h_i});

  // zero width or height fails the strict less-than, so it never hits
  assign hit_o = in_x && in_y;
endmodule

// File: rtl/pong_sprite_compositor.sv
// rtl/pong_sprite_compositor.sv - two-stage sprite compositor with frame-swapped geometry; PONG_CENTER_NET_EN adds a dashed centre net
module pong_sprite_compositor
  import pong_gfx_pkg::*;
#(
  parameter int COORD_W  = 16,
  parameter int N_OBJ    = 3,
  parameter int COLOUR_W = 8
`ifdef PONG_CENTER_NET_EN
  ,
  parameter logic [COORD_W-1:0]  NET_X      = 16'd312,
  parameter logic [COORD_W-1:0]  NET_W      = 16'd4,
  parameter logic [COORD_W-1:0]  NET_DASH   = 16'd16,
  parameter logic [COLOUR_W-1:0] NET_COLOUR = COLOUR_WHITE
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_start,
  input  logic [N_OBJ*2*COORD_W-1:0]    obj_pos,
  input  logic [N_OBJ*2*COORD_W-1:0]    obj_size,
  input  logic [N_OBJ*COLOUR_W-1:0]     obj_colour,
  input  logic [COLOUR_W-1:0]           bg_colour,
  output logic [N_OBJ-1:0]              collision_mask,
  pong_sprite_compositor_if.slave       vid
);
  localparam int OBJ_W = $clog2(N_OBJ + 1);

  // shadow geometry and colours; col_old_q keeps the pre-swap colours for a
  // pixel that was hit-tested in the swap cycle and finishes after it
  logic [N_OBJ*2*COORD_W-1:0] pos_q;
  logic [N_OBJ*2*COORD_W-1:0] size_q;
  logic [N_OBJ*COLOUR_W-1:0]  col_q;
  logic [N_OBJ*COLOUR_W-1:0]  col_old_q;

  // stage 1
  logic [N_OBJ-1:0] hit_d;
  logic [N_OBJ-1:0] hv_q;
  logic             s1_valid_q;
  logic             s1_old_q;

  // stage 2
  logic [N_OBJ*COLOUR_W-1:0] col_sel;
  logic [COLOUR_W-1:0]       colour_d;
  logic [OBJ_W-1:0]          obj_d;
  logic                      pix_valid_q;
  logic [COLOUR_W-1:0]       pix_colour_q;
  logic [OBJ_W-1:0]          pix_obj_q;

  // collision accumulation
  logic             hv_multi;
  logic [N_OBJ-1:0] qual_hv;
  logic [N_OBJ-1:0] acc_d;
  logic [N_OBJ-1:0] acc_q;
  logic [N_OBJ-1:0] mask_d;
  logic [N_OBJ-1:0] mask_q;

  // swap all object state only at frame start so a frame never tears
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q     <= '0;
      size_q    <= '0;
      col_q     <= '0;
      col_old_q <= '0;
    end else if (frame_start) begin
      pos_q     <= obj_pos;
      size_q    <= obj_size;
      col_old_q <= col_q;
      col_q     <= obj_colour;
    end
  end

  genvar g;
  generate
    for (g = 0; g < N_OBJ; g++) begin : g_hit
      rect_hit_test #(.COORD_W(COORD_W)) u_hit (
        .rect_x_i (pos_q [g*2*COORD_W + COORD_W +: COORD_W]),
        .rect_y_i (pos_q [g*2*COORD_W           +: COORD_W]),
        .rect_w_i (size_q[g*2*COORD_W + COORD_W +: COORD_W]),
        .rect_h_i (size_q[g*2*COORD_W           +: COORD_W]),
        .px_x_i   (vid.px_x),
        .px_y_i   (vid.px_y),
        .hit_o    (hit_d[g])
      );
    end
  endgenerate

  // stage 1: register the hit vector against the shadow in force this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hv_q       <= '0;
      s1_valid_q <= 1'b0;
      s1_old_q   <= 1'b0;
    end else begin
      hv_q       <= vid.px_valid ? hit_d : '0;
      s1_valid_q <= vid.px_valid;
      s1_old_q   <= frame_start;
    end
  end

`ifdef PONG_CENTER_NET_EN
  localparam int DASH_BIT = $clog2(NET_DASH);

  logic [COORD_W:0] net_dx;
  logic             net_d;
  logic             net_q;

  assign net_dx = {1'b0, vid.px_x} - {1'b0, NET_X};
  assign net_d  = vid.px_valid && (vid.px_x >= NET_X) &&
                  (net_dx < {1'b0, NET_W}) && !vid.px_y[DASH_BIT];

  // stage 1: net membership travels alongside the hit vector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      net_q <= 1'b0;
    end else begin
      net_q <= net_d;
    end
  end
`endif

  assign col_sel = s1_old_q ? col_old_q : col_q;

  // stage 2 select: lowest hit index wins, then net, then background
  always_comb begin
    colour_d = bg_colour;
    obj_d    = OBJ_W'(N_OBJ);
`ifdef PONG_CENTER_NET_EN
    if (net_q) begin
      colour_d = NET_COLOUR;
    end
`endif
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (hv_q[i]) begin
        colour_d = col_sel[i*COLOUR_W +: COLOUR_W];
        obj_d    = OBJ_W'(i);
      end
    end
  end

  // stage 2: output register, holds the last pixel between valid slots
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_valid_q  <= 1'b0;
      pix_colour_q <= '0;
      pix_obj_q    <= OBJ_W'(N_OBJ);
    end else begin
      pix_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        pix_colour_q <= colour_d;
        pix_obj_q    <= obj_d;
      end
    end
  end

  // a hit vector with two or more bits set means those objects overlap here
  assign hv_multi = s1_valid_q && (|(hv_q & (hv_q - N_OBJ'(1))));
  assign qual_hv  = hv_multi ? hv_q : '0;

  // roll the accumulator into the mask at frame start, including this cycle's hits
  always_comb begin
    acc_d  = acc_q | qual_hv;
    mask_d = mask_q;
    if (frame_start) begin
      mask_d = acc_q | qual_hv;
      acc_d  = '0;
    end
  end

  // collision state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      mask_q <= '0;
    end else begin
      acc_q  <= acc_d;
      mask_q <= mask_d;
    end
  end

  assign vid.pix_valid   = pix_valid_q;
  assign vid.pix_colour  = pix_colour_q;
  assign vid.pix_obj     = pix_obj_q;
  assign collision_mask  = mask_q;
endmodule

// File: tb/tb_pong_sprite_compositor.sv
// tb/tb_pong_sprite_compositor.sv - self-checking bench for pong_sprite_compositor
module tb_pong_sprite_compositor;
  localparam int CW = 16;
  localparam int N  = 3;
  localparam int LW = 8;
  localparam int BG = 8'h5A;

  logic              clk = 1'b0;
  logic              rst;
  logic              frame_start;
  logic [N*2*CW-1:0] obj_pos;
  logic [N*2*CW-1:0] obj_size;
  logic [N*LW-1:0]   obj_colour;
  logic [LW-1:0]     bg_colour;
  logic [N-1:0]      collision_mask;

  pong_sprite_compositor_if #(.COORD_W(CW), .N_OBJ(N), .COLOUR_W(LW)) vif ();

  pong_sprite_compositor #(.COORD_W(CW), .N_OBJ(N), .COLOUR_W(LW)) dut (
    .clk            (clk),
    .rst            (rst),
    .frame_start    (frame_start),
    .obj_pos        (obj_pos),
    .obj_size       (obj_size),
    .obj_colour     (obj_colour),
    .bg_colour      (bg_colour),
    .collision_mask (collision_mask),
    .vid            (vif)
  );

  always #5 clk = ~clk;

  // requested object state (inputs) and the model's view of the shadow
  int in_x[N], in_y[N], in_w[N], in_h[N], in_c[N];
  int sh_x[N], sh_y[N], sh_w[N], sh_h[N], sh_c[N];
  int acc, mask, pend_hv;
  bit prev_v, prev_bg;
  int prev_idx, prev_col;
  int n_assert = 0;
  int n_fail   = 0;

  function automatic int model_hits(input int x, input int y);
    int r = 0;
    for (int i = 0; i < N; i++)
      if (sh_w[i] != 0 && sh_h[i] != 0 && x >= sh_x[i] && (x - sh_x[i]) < sh_w[i] &&
          y >= sh_y[i] && (y - sh_y[i]) < sh_h[i])
        r |= (1 << i);
    return r;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_obj(input int i, input int x, input int y, input int w, input int h, input int c);
    in_x[i] = x; in_y[i] = y; in_w[i] = w; in_h[i] = h; in_c[i] = c;
  endtask

  task automatic pack_objs();
    for (int i = 0; i < N; i++) begin
      obj_pos[i*2*CW +: 2*CW]  = {16'(in_x[i]), 16'(in_y[i])};
      obj_size[i*2*CW +: 2*CW] = {16'(in_w[i]), 16'(in_h[i])};
      obj_colour[i*LW +: LW]   = 8'(in_c[i]);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      sh_x[i] = 0; sh_y[i] = 0; sh_w[i] = 0; sh_h[i] = 0; sh_c[i] = 0;
    end
    acc = 0; mask = 0; pend_hv = 0;
    prev_v = 0; prev_bg = 1; prev_idx = N; prev_col = 0;
  endtask

  // one clock: drive, advance the model, then check what the edge produced
  task automatic step(input bit fs, input bit pv, input int x, input int y);
    int cur_hv, q, idx, col;
    bit use_bg;
    frame_start  = fs;
    vif.px_valid = pv;
    vif.px_x     = 16'(x);
    vif.px_y     = 16'(y);
    pack_objs();
    cur_hv = pv ? model_hits(x, y) : 0;
    idx = N; col = 0; use_bg = 1;
    for (int i = N - 1; i >= 0; i--)
      if (cur_hv[i]) begin idx = i; col = sh_c[i]; use_bg = 0; end
`ifdef PONG_CENTER_NET_EN
    if (pv && use_bg && x >= 312 && x < 316 && ((y / 16) % 2) == 0) begin
      col = 8'hFF; use_bg = 0;
    end
`endif
    q = ($countones(pend_hv) >= 2) ? pend_hv : 0;
    if (fs) begin mask = acc | q; acc = 0; end
    else acc = acc | q;
    pend_hv = cur_hv;
    if (fs)
      for (int i = 0; i < N; i++) begin
        sh_x[i] = in_x[i]; sh_y[i] = in_y[i]; sh_w[i] = in_w[i]; sh_h[i] = in_h[i]; sh_c[i] = in_c[i];
      end
    @(posedge clk); #1;
    chk("pix_valid", vif.pix_valid, prev_v);
    if (prev_v) begin
      chk("pix_colour", vif.pix_colour, prev_bg ? int'(bg_colour) : prev_col);
      chk("pix_obj", vif.pix_obj, prev_idx);
    end
    chk("collision_mask", collision_mask, mask);
    prev_v = pv; prev_idx = idx; prev_col = col; prev_bg = use_bg;
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; bg_colour = 8'(BG);
    vif.px_valid = 1'b0; vif.px_x = '0; vif.px_y = '0;
    for (int i = 0; i < N; i++) set_obj(i, 0, 0, 0, 0, 0);
    pack_objs();
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pix_valid", vif.pix_valid, 0);
    chk("reset_pix_colour", vif.pix_colour, 0);
    chk("reset_pix_obj", vif.pix_obj, N);
    chk("reset_mask", collision_mask, 0);
    rst = 1'b0;

    // reset shadow is empty: a whole line is background even with inputs set
    set_obj(0, 10, 20, 15, 100, 8'h11);
    for (int x = 0; x < 64; x++) step(0, 1, x, 20);
    step(0, 0, 0, 0);
    chk("line_last_obj", vif.pix_obj, N);
    chk("line_last_colour", vif.pix_colour, BG);

    // basic hit and exclusive right edge
    set_obj(1, 200, 200, 10, 10, 8'h22);
    set_obj(2, 40, 40, 20, 20, 8'h33);
    step(1, 0, 0, 0);
    step(0, 1, 10, 20);
    step(0, 1, 25, 20);
    chk("hit_colour", vif.pix_colour, 8'h11);
    chk("hit_obj", vif.pix_obj, 0);
    step(0, 0, 0, 0);
    chk("edge_colour", vif.pix_colour, BG);
    chk("edge_obj", vif.pix_obj, N);

    // overlap of obj0 and obj2 at (50,50)
    set_obj(0, 10, 20, 60, 100, 8'h11);
    step(1, 0, 0, 0);
    step(0, 1, 50, 50);
    step(0, 0, 0, 0);
    chk("overlap_colour", vif.pix_colour, 8'h11);
    step(1, 0, 0, 0);
    chk("overlap_mask", collision_mask, 3'b101);
    step(1, 0, 0, 0);
    chk("clear_mask", collision_mask, 0);

    // tear guard
    set_obj(0, 300, 20, 60, 100, 8'h11);
    step(0, 1, 10, 20);
    step(1, 1, 10, 20);
    chk("tear_no_swap", vif.pix_colour, 8'h11);
    step(0, 1, 10, 20);
    chk("tear_swap_cycle", vif.pix_colour, 8'h11);
    step(0, 0, 0, 0);
    chk("tear_after_swap", vif.pix_obj, N);

    // clipping at the coordinate limit
    set_obj(1, 16'hFFF8, 0, 16, 16, 8'h44);
    set_obj(2, 0, 0, 0, 5, 8'h33);
    step(1, 0, 0, 0);
    step(0, 1, 16'hFFFF, 0);
    step(0, 1, 0, 0);
    chk("clip_hit_colour", vif.pix_colour, 8'h44);
    chk("clip_hit_obj", vif.pix_obj, 1);
    step(0, 0, 0, 0);
    chk("clip_nowrap_obj", vif.pix_obj, N);

`ifdef PONG_CENTER_NET_EN
    set_obj(0, 313, 0, 2, 10, 8'h77);
    step(1, 0, 0, 0);
    step(0, 1, 312, 0);
    step(0, 1, 312, 16);
    chk("net_colour", vif.pix_colour, 8'hFF);
    chk("net_obj", vif.pix_obj, N);
    step(0, 1, 313, 3);
    chk("net_gap", vif.pix_colour, BG);
    step(0, 0, 0, 0);
    chk("paddle_over_net", vif.pix_colour, 8'h77);
`endif

    // reset mid-stream discards in-flight pixels
    step(0, 1, 5, 5);
    step(0, 1, 6, 5);
    rst = 1'b1;
    frame_start = 1'b0;
    vif.px_valid = 1'b0;
    model_clear();
    #2;
    chk("midreset_valid", vif.pix_valid, 0);
    chk("midreset_mask", collision_mask, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // randomized frames against the model
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++)
        set_obj(i, $urandom_range(0, 100), $urandom_range(0, 100),
                $urandom_range(0, 60), $urandom_range(0, 60), $urandom_range(0, 255));
      step(1, 0, 0, 0);
      for (int k = 0; k < 300; k++) begin
        bg_colour = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 40) == 0) set_obj($urandom_range(0, N - 1), $urandom_range(0, 100),
            $urandom_range(0, 100), $urandom_range(0, 60), $urandom_range(0, 60), $urandom_range(0, 255));
        step($urandom_range(0, 30) == 0, $urandom_range(0, 9) < 8,
             $urandom_range(0, 127), $urandom_range(0, 127));
      end
    end
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/pong_sprite_compositor.md
# pong_sprite_compositor

Parametrised, pipelined pixel generator for the pong display path. Takes a stream of raster coordinates and returns one colour per coordinate by testing it against N rectangular objects (paddles, ball, extras), with fixed index priority. Object geometry is double-buffered and swapped only at frame start, so positions never tear mid-frame. Per-frame object-overlap flags are accumulated and handed to game logic for collision handling. Sits between the raster/timing generator and the video output encoder.

## Interface
- `COORD_W`, 16: coordinate width, unsigned.
- `N_OBJ`, 3: number of objects. Range 1..16.
- `COLOUR_W`, 8: colour width.
- `NET_X`, 16'd312: net left edge. Used only with the macro.
- `NET_W`, 16'd4: net width. Used only with the macro.
- `NET_DASH`, 16'd16: net dash period, a power of two. Used only with the macro.
- `NET_COLOUR`, 8'hFF: net colour. Used only with the macro.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `frame_start` in 1: one-cycle pulse. Swaps the shadow registers and rolls the collision accumulator.
- `obj_pos` in N_OBJ*2*COORD_W: object i occupies `[i*2*COORD_W +: 2*COORD_W]`, laid out as {x, y}, with x in the upper half.
- `obj_size` in N_OBJ*2*COORD_W: {w, h} per object, same layout as `obj_pos`.
- `obj_colour` in N_OBJ*COLOUR_W: colour of object i at `[i*COLOUR_W +: COLOUR_W]`.
- `bg_colour` in COLOUR_W: background colour. Not shadowed.
- `px_valid` in 1: a coordinate is presented this cycle.
- `px_x`, `px_y` in COORD_W: raster coordinate.
- `pix_valid` out 1: a result is available.
- `pix_colour` out COLOUR_W: resulting colour.
- `pix_obj` out $clog2(N_OBJ+1): index of the winning object; N_OBJ means none.
- `collision_mask` out N_OBJ: objects that overlapped any other object during the previous frame.

## Operation
- Shadow registers hold pos, size and colour for every object. They load from the inputs in the cycle `frame_start`=1 and are stable otherwise.
- Hit test for object i, in COORD_W+1 bits, all unsigned:
  - Hit when `px_x >= x_i` and `(px_x - x_i) < w_i`.
  - The same test applies on y with `h_i`.
  - w or h = 0 never hits.
  - Rectangles that run past the maximum coordinate are clipped. No wrap to 0.
- Priority: the lowest hit index wins. `pix_colour` = that object's colour and `pix_obj` = its index. With no hit, `pix_colour` = `bg_colour` and `pix_obj` = N_OBJ.
- Collision accumulator:
  - Reads the registered stage-1 hit vector `hv`.
  - When `hv` is valid and popcount(`hv`) >= 2, bits `hv` are OR-ed into the accumulator.
- On `frame_start`:
  - `collision_mask` <= accumulator | (this cycle's qualifying `hv`).
  - The accumulator then clears to 0.
  - `collision_mask` holds until the next `frame_start`.
- No back-pressure. Every `px_valid` produces exactly one `pix_valid`.

## Timing
- Stage 1 registers `hv[N_OBJ-1:0]` and valid. Stage 2 registers `pix_colour`, `pix_obj` and `pix_valid`. Latency is exactly 2 cycles, throughput 1 pixel/cycle.
- `bg_colour` is sampled in stage 2.
- A `px_valid` in the same cycle as `frame_start` is tested against the old shadow. Pixels from cycle+1 onward use the new shadow.
- A pixel whose stage-1 `hv` registers in the `frame_start` cycle counts toward the closing frame's mask. Later pixels count toward the new frame.
- Back-to-back `frame_start` pulses are legal. Each pulse rolls the mask.
- Reset values:
  - All shadow registers are 0, so no object hits until the first `frame_start`.
  - Accumulator, `collision_mask`, `pix_valid` and `pix_colour` are 0. `pix_obj` = N_OBJ.
  - Pipeline valids are 0.
- Reset mid-stream discards in-flight pixels. No `pix_valid` is produced for them.

## Configuration
- `PONG_CENTER_NET_EN` defined:
  - A dashed net is drawn at `px_x` in [NET_X, NET_X+NET_W) when bit log2(NET_DASH) of `px_y` is 0.
  - Priority is below every object and above the background.
  - `pix_obj` = N_OBJ for net pixels.
  - The net never contributes to collisions.
- Undefined: no net logic is compiled, and the NET_* parameters are ignored.

## Structure
- Package `pong_gfx_pkg` holds:
  - `COLOUR_WHITE` = 8'hFF and `COLOUR_BLACK` = 8'h00.
  - Typedefs `coord_t` and `colour_t`.
  - Packed struct `obj_rect_t` {x, y, w, h}.
- Sub-module `rect_hit_test` is combinational. It takes one rectangle and one coordinate and returns a hit bit. It is instantiated N_OBJ times in a generate loop.

## Test plan
- Reset, then `frame_start` with obj0 at (10,20) size (15,100) and colour 8'h11:
  - px (10,20) -> 8'h11, obj 0, 2 cycles later.
  - px (25,20) -> bg, obj N_OBJ (right edge is exclusive).
- Overlapping objects: obj0 and obj2 both cover (50,50) -> obj0's colour. At the next `frame_start`, `collision_mask` = 3'b101. After a further frame with no overlap, the mask is 0.
- Tear guard: change `obj_pos` without `frame_start` -> output unchanged. Pulse `frame_start` in the same cycle as px (10,20) -> that pixel uses the old geometry and the next pixel uses the new.
- Edge clip: object at (16'hFFF8,0) size (16,16) -> px (16'hFFFF,0) hits, px (0,0) does not.
- Zero size, and the reset state with no `frame_start`: streaming a full line -> all bg, `pix_obj` = N_OBJ, no collisions.
- With `PONG_CENTER_NET_EN`:
  - px (312,0) -> 8'hFF, and px (312,16) -> bg.
  - A paddle over (313,3) wins over the net.
